// File: rtl/uart_ctrl_seq_if.sv
// Signal bundle between the UART control sequencer and its environment
// (control register, TX data register, TX/RX cores, RX data register).
interface uart_ctrl_seq_if #(
  parameter int ANCHO = 32
);
  logic [ANCHO-1:0] ctrl_i;
  logic [7:0]       tx_data_i;
  logic             tx_done_i;
  logic             rx_valid_i;
  logic [7:0]       rx_data_i;
  logic             clr_err_i;
  logic             tx_start_o;
  logic [7:0]       tx_data_o;
  logic             clear_send_o;
  logic             set_new_o;
  logic             rx_wr_o;
  logic [7:0]       rx_data_o;
  logic             busy_o;
  logic             timeout_o;
  logic             overrun_o;

  modport master (
    input  ctrl_i, tx_data_i, tx_done_i, rx_valid_i, rx_data_i, clr_err_i,
    output tx_start_o, tx_data_o, clear_send_o, set_new_o, rx_wr_o,
           rx_data_o, busy_o, timeout_o, overrun_o
  );

  modport slave (
    output ctrl_i, tx_data_i, tx_done_i, rx_valid_i, rx_data_i, clr_err_i,
    input  tx_start_o, tx_data_o, clear_send_o, set_new_o, rx_wr_o,
           rx_data_o, busy_o, timeout_o, overrun_o
  );
endinterface

// File: rtl/uart_ctrl_seq.sv
// UART control sequencer: launches one TX byte per send request and hands
// received bytes to the RX data register, with sticky timeout/overrun flags.
module uart_ctrl_seq #(
  parameter int ANCHO   = 32,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  uart_ctrl_seq_if.master  bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_WAIT_DONE = 3'd2;
  localparam logic [2:0] ST_CLEAR     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_r;
  logic [2:0]    state_nxt_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          load_s;
  logic          tmo_evt_s;
  logic          ovr_evt_s;

  logic          tx_start_r;
  logic [7:0]    tx_data_r;
  logic          clear_send_r;
  logic          busy_r;
  logic          timeout_r;
  logic          set_new_r;
  logic          rx_wr_r;
  logic [7:0]    rx_data_r;
  logic          overrun_r;

  logic          unused_ctrl_s;

  assign unused_ctrl_s = ^bus.ctrl_i[ANCHO-1:2];

  // TX next-state and timeout counter logic
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    tmo_evt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.ctrl_i[0]) begin
          load_s      = 1'b1;
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_nxt_s   = {CW{1'b0}};
        state_nxt_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // done wins over an expiry landing in the same cycle
        if (bus.tx_done_i) begin
          state_nxt_s = ST_CLEAR;
        end else if (cnt_r == CNT_LAST) begin
          tmo_evt_s   = 1'b1;
          state_nxt_s = ST_CLEAR;
        end else begin
          cnt_nxt_s   = cnt_r + CW'(1);
        end
      end
      ST_CLEAR: begin
        state_nxt_s = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (!bus.ctrl_i[0]) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  assign ovr_evt_s = bus.rx_valid_i & bus.ctrl_i[1];

  // TX state, counter and registered Moore outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {CW{1'b0}};
      tx_start_r   <= 1'b0;
      tx_data_r    <= 8'h00;
      clear_send_r <= 1'b0;
      busy_r       <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      tx_start_r   <= (state_nxt_s == ST_LOAD);
      clear_send_r <= (state_nxt_s == ST_CLEAR);
      busy_r       <= (state_nxt_s != ST_IDLE);
      timeout_r    <= tmo_evt_s | (timeout_r & ~bus.clr_err_i);
      if (load_s) begin
        tx_data_r <= bus.tx_data_i;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  // RX capture path, independent of the TX sequencer
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      set_new_r <= 1'b0;
      rx_wr_r   <= 1'b0;
      rx_data_r <= 8'h00;
      overrun_r <= 1'b0;
    end else begin
      set_new_r <= bus.rx_valid_i;
      rx_wr_r   <= bus.rx_valid_i;
      overrun_r <= ovr_evt_s | (overrun_r & ~bus.clr_err_i);
      if (bus.rx_valid_i) begin
        rx_data_r <= bus.rx_data_i;
      end else begin
        rx_data_r <= rx_data_r;
      end
    end
  end

  assign bus.tx_start_o   = tx_start_r;
  assign bus.tx_data_o    = tx_data_r;
  assign bus.clear_send_o = clear_send_r;
  assign bus.set_new_o    = set_new_r;
  assign bus.rx_wr_o      = rx_wr_r;
  assign bus.rx_data_o    = rx_data_r;
  assign bus.busy_o       = busy_r;
  assign bus.timeout_o    = timeout_r;
  assign bus.overrun_o    = overrun_r;

endmodule

// File: tb/tb_uart_ctrl_seq.sv
// Self-checking bench for uart_ctrl_seq: directed and randomized TX/RX
// scenarios compared against a timing/flag model derived from the behaviour.
module tb_uart_ctrl_seq;

  localparam int TMO = 16;

  logic clk_i = 1'b0;
  logic rst_ni;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       model_to = 1'b0;
  logic       model_ov = 1'b0;
  logic [7:0] model_rxd = 8'h00;

  typedef struct packed {
    logic       v;
    logic       nw;
    logic       clr;
    logic [7:0] d;
  } rx_step_t;

  uart_ctrl_seq_if #(.ANCHO(32)) bus ();

  uart_ctrl_seq #(.ANCHO(32), .TIMEOUT(TMO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    logic [26:0] outs;
    rst_ni = 1'b0;
    bus.ctrl_i = 32'h0; bus.tx_data_i = 8'h00; bus.tx_done_i = 1'b0;
    bus.rx_valid_i = 1'b0; bus.rx_data_i = 8'h00; bus.clr_err_i = 1'b0;
    #12;
    outs = {bus.tx_start_o, bus.tx_data_o, bus.clear_send_o, bus.set_new_o, bus.rx_wr_o,
            bus.rx_data_o, bus.busy_o, bus.timeout_o, bus.overrun_o};
    n_cmp++;
    if (outs !== 27'h0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    outs = {bus.tx_start_o, bus.tx_data_o, bus.clear_send_o, bus.set_new_o, bus.rx_wr_o,
            bus.rx_data_o, bus.busy_o, bus.timeout_o, bus.overrun_o};
    n_cmp++;
    if (outs !== 27'h0) begin n_bad++; $display("FAIL idle_after_reset: got %h want 0", outs); end
  endtask

  // One send request: done arrives d cycles into the wait (d >= TMO means never),
  // send stays high for hold extra cycles after the clear pulse.
  task automatic tx_txn(input logic [7:0] data, input int d, input int hold, input bit stray);
    int         gap;
    logic       exp_to;
    logic [31:0] r;
    gap    = 2 + ((d < TMO) ? d : TMO - 1);
    exp_to = model_to | (d >= TMO);
    r = $urandom();
    bus.ctrl_i    = {r[31:1], 1'b1};
    bus.tx_data_i = data;
    tick();
    for (int c = 0; c <= gap; c++) begin
      n_cmp++;
      if (bus.tx_start_o !== (c == 0)) begin
        n_bad++; $display("FAIL tx_start c=%0d: got %b want %b", c, bus.tx_start_o, (c == 0));
      end
      n_cmp++;
      if (bus.tx_data_o !== data) begin
        n_bad++; $display("FAIL tx_data c=%0d: got %h want %h", c, bus.tx_data_o, data);
      end
      n_cmp++;
      if (bus.clear_send_o !== (c == gap)) begin
        n_bad++; $display("FAIL clear_send c=%0d: got %b want %b", c, bus.clear_send_o, (c == gap));
      end
      n_cmp++;
      if (bus.busy_o !== 1'b1) begin
        n_bad++; $display("FAIL busy c=%0d: got %b want 1", c, bus.busy_o);
      end
      if (c == gap) begin
        n_cmp++;
        if (bus.timeout_o !== exp_to) begin
          n_bad++; $display("FAIL timeout_flag d=%0d: got %b want %b", d, bus.timeout_o, exp_to);
        end
      end
      bus.tx_done_i = (c == d + 1) || (stray && c == 0);
      r = $urandom();
      bus.tx_data_i = r[7:0];
      if (c < gap) tick();
    end
    model_to = exp_to;
    bus.tx_done_i = 1'b0;
    tick();
    for (int h = 0; h <= hold; h++) begin
      n_cmp++;
      if ({bus.tx_start_o, bus.clear_send_o, bus.busy_o} !== 3'b001) begin
        n_bad++;
        $display("FAIL wait_ack h=%0d: got start/clr/busy %b want 001", h,
                 {bus.tx_start_o, bus.clear_send_o, bus.busy_o});
      end
      bus.tx_done_i = stray;
      if (h < hold) tick();
    end
    bus.tx_done_i = 1'b0;
    bus.ctrl_i[0] = 1'b0;
    tick();
    n_cmp++;
    if ({bus.tx_start_o, bus.clear_send_o, bus.busy_o} !== 3'b000) begin
      n_bad++;
      $display("FAIL back_to_idle: got start/clr/busy %b want 000",
               {bus.tx_start_o, bus.clear_send_o, bus.busy_o});
    end
  endtask

  task automatic test_tx_basic();
    tx_txn(8'h55, 10, 2, 1'b0);
    tick();
    n_cmp++;
    if (bus.tx_start_o !== 1'b0) begin
      n_bad++; $display("FAIL no_relaunch: got %b want 0", bus.tx_start_o);
    end
  endtask

  task automatic test_timeout();
    tx_txn(8'hA5, 1000, 0, 1'b0);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    model_to = 1'b0;
    n_cmp++;
    if (bus.timeout_o !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: got %b want 0", bus.timeout_o);
    end
  endtask

  task automatic test_expiry_edge();
    tx_txn(8'h0F, TMO - 1, 0, 1'b1);
    tx_txn(8'hF0, TMO, 0, 1'b0);
  endtask

  task automatic test_hold_send();
    tx_txn(8'h81, 3, 6, 1'b1);
  endtask

  task automatic test_rx();
    rx_step_t    tbl [10];
    rx_step_t    s;
    logic [31:0] r;
    logic [7:0]  exp_rxd;
    logic        exp_ov;
    logic        exp_to;
    tbl = '{'{1'b1, 1'b0, 1'b0, 8'hA3}, '{1'b1, 1'b1, 1'b0, 8'h3C}, '{1'b0, 1'b0, 1'b0, 8'h00},
            '{1'b1, 1'b0, 1'b0, 8'h22}, '{1'b1, 1'b0, 1'b0, 8'h33}, '{1'b1, 1'b0, 1'b0, 8'h44},
            '{1'b1, 1'b0, 1'b0, 8'h55}, '{1'b0, 1'b0, 1'b1, 8'h00}, '{1'b1, 1'b1, 1'b1, 8'h66},
            '{1'b0, 1'b0, 1'b0, 8'h00}};
    for (int i = 0; i < 50; i++) begin
      r = $urandom();
      if (i < 10) s = tbl[i];
      else s = '{r[0] | r[1], r[2], (r[5:3] == 3'b000), r[15:8]};
      bus.rx_valid_i = s.v;
      bus.rx_data_i  = s.d;
      bus.clr_err_i  = s.clr;
      bus.ctrl_i     = {r[31:16], 14'h0, s.nw, 1'b0};
      exp_rxd = s.v ? s.d : model_rxd;
      exp_ov  = (s.v && s.nw) || (model_ov && !s.clr);
      exp_to  = model_to && !s.clr;
      tick();
      model_rxd = exp_rxd; model_ov = exp_ov; model_to = exp_to;
      n_cmp++;
      if ({bus.rx_wr_o, bus.set_new_o} !== {s.v, s.v}) begin
        n_bad++; $display("FAIL rx_strobes i=%0d: got %b want %b", i, {bus.rx_wr_o, bus.set_new_o}, {s.v, s.v});
      end
      n_cmp++;
      if (bus.rx_data_o !== exp_rxd) begin
        n_bad++; $display("FAIL rx_data i=%0d: got %h want %h", i, bus.rx_data_o, exp_rxd);
      end
      n_cmp++;
      if ({bus.overrun_o, bus.timeout_o} !== {exp_ov, exp_to}) begin
        n_bad++; $display("FAIL err_flags i=%0d: got ov/to %b want %b", i,
                          {bus.overrun_o, bus.timeout_o}, {exp_ov, exp_to});
      end
      n_cmp++;
      if ({bus.tx_start_o, bus.busy_o} !== 2'b00) begin
        n_bad++; $display("FAIL rx_tx_quiet i=%0d: got %b want 00", i, {bus.tx_start_o, bus.busy_o});
      end
    end
    bus.rx_valid_i = 1'b0;
    bus.clr_err_i  = 1'b0;
    bus.ctrl_i     = 32'h0;
  endtask

  task automatic test_random_tx();
    logic [31:0] r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom();
      tx_txn(r[7:0], $urandom_range(0, TMO + 4), $urandom_range(0, 3), r[8]);
    end
  endtask

  task automatic test_reset_mid();
    logic [26:0] outs;
    bus.ctrl_i = 32'h3; bus.tx_data_i = 8'hC7;
    bus.rx_valid_i = 1'b1; bus.rx_data_i = 8'h5A;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.ctrl_i = 32'h1;
    tick(); tick(); tick();
    n_cmp++;
    if ({bus.busy_o, bus.overrun_o} !== 2'b11) begin
      n_bad++; $display("FAIL pre_reset_state: got %b want 11", {bus.busy_o, bus.overrun_o});
    end
    #3 rst_ni = 1'b0;
    #1;
    outs = {bus.tx_start_o, bus.tx_data_o, bus.clear_send_o, bus.set_new_o, bus.rx_wr_o,
            bus.rx_data_o, bus.busy_o, bus.timeout_o, bus.overrun_o};
    n_cmp++;
    if (outs !== 27'h0) begin n_bad++; $display("FAIL async_reset: got %h want 0", outs); end
    model_to = 1'b0; model_ov = 1'b0; model_rxd = 8'h00;
    @(posedge clk_i);
    #3;
    bus.tx_data_i = 8'h3E;
    rst_ni = 1'b1;
    tick();
    n_cmp++;
    if ({bus.tx_start_o, bus.tx_data_o, bus.busy_o} !== {1'b1, 8'h3E, 1'b1}) begin
      n_bad++; $display("FAIL restart_launch: got start/data/busy %b/%h/%b want 1/3e/1",
                        bus.tx_start_o, bus.tx_data_o, bus.busy_o);
    end
    tick();
    bus.tx_done_i = 1'b1;
    tick();
    bus.tx_done_i = 1'b0;
    bus.ctrl_i = 32'h0;
    n_cmp++;
    if ({bus.clear_send_o, bus.timeout_o} !== 2'b10) begin
      n_bad++; $display("FAIL restart_clear: got clr/to %b want 10", {bus.clear_send_o, bus.timeout_o});
    end
    tick(); tick();
    n_cmp++;
    if (bus.busy_o !== 1'b0) begin
      n_bad++; $display("FAIL restart_idle: got %b want 0", bus.busy_o);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tx_basic();
    test_timeout();
    test_expiry_edge();
    test_hold_send();
    test_rx();
    test_random_tx();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
